// File: rtl/timer_pkg.sv
// Shared definitions for the down-counting interval timer: state encoding
// and default widths used by the top and the prescaler.
package timer_pkg;

  localparam int TIMER_WIDTH    = 16;
  localparam int TIMER_PS_WIDTH = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } timer_state_e;

endpackage

// File: rtl/timer_prescaler.sv
// Prescale divider: emits a one-cycle step strobe every (max+1) enabled
// cycles while the timer is running; clr restarts the divide sequence.
module timer_prescaler
  import timer_pkg::*;
#(
  parameter int PS_WIDTH = TIMER_PS_WIDTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                en,
  input  logic                run,
  input  logic [PS_WIDTH-1:0] max,
  output logic                step
);

  localparam logic [PS_WIDTH-1:0] PS_ONE = {{(PS_WIDTH-1){1'b0}}, 1'b1};

  logic [PS_WIDTH-1:0] r_pre_cnt;
  logic                w_at_max;

  assign w_at_max = (r_pre_cnt == max);
  assign step     = run && en && w_at_max;

  // Wraps to zero on the step so every prescaled period has the same length.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pre_cnt <= '0;
    end else if (clr) begin
      r_pre_cnt <= '0;
    end else if (run && en) begin
      if (w_at_max) begin
        r_pre_cnt <= '0;
      end else begin
        r_pre_cnt <= r_pre_cnt + PS_ONE;
      end
    end
  end

endmodule

// File: rtl/down_timer.sv
// Loadable down-counting interval timer with prescaler, one-shot and
// auto-reload modes, abort, and a registered one-cycle expire pulse.
module down_timer
  import timer_pkg::*;
#(
  parameter int WIDTH    = TIMER_WIDTH,
  parameter int PS_WIDTH = TIMER_PS_WIDTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                load_valid,
  output logic                load_ready,
  input  logic [WIDTH-1:0]    load_value,
  input  logic [PS_WIDTH-1:0] load_prescale,
  input  logic                load_auto,
  input  logic                stop,
  output logic [WIDTH-1:0]    count,
  output logic                busy,
  output logic                expire
);

  localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  timer_state_e        r_state;
  logic [WIDTH-1:0]    r_count;
  logic [WIDTH-1:0]    r_reload;
  logic [PS_WIDTH-1:0] r_pre_max;
  logic                r_auto;
  logic                r_expire;

  logic w_run;
  logic w_accept;
  logic w_abort;
  logic w_step;

  assign w_run    = (r_state == ST_RUN);
  assign w_accept = load_valid && !w_run;
  assign w_abort  = stop && w_run;

  assign load_ready = !w_run;
  assign busy       = w_run;
  assign count      = r_count;
  assign expire     = r_expire;

  timer_prescaler #(
    .PS_WIDTH(PS_WIDTH)
  ) u_prescaler (
    .clk (clk),
    .rst (rst),
    .clr (w_accept || w_abort),
    .en  (en),
    .run (w_run),
    .max (r_pre_max),
    .step(w_step)
  );

  // Abort beats a coincident step, so a stopped timer never decrements or expires.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_count   <= '0;
      r_reload  <= '0;
      r_pre_max <= '0;
      r_auto    <= 1'b0;
      r_expire  <= 1'b0;
    end else begin
      r_expire <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (load_valid) begin
            r_count   <= load_value;
            r_reload  <= load_value;
            r_pre_max <= load_prescale;
            r_auto    <= load_auto;
            r_state   <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (stop) begin
            r_state <= ST_IDLE;
          end else if (w_step) begin
            if (r_count != '0) begin
              r_count <= r_count - CNT_ONE;
            end else begin
              r_expire <= 1'b1;
              if (r_auto) begin
                r_count <= r_reload;
              end else begin
                r_state <= ST_IDLE;
              end
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_down_timer.sv
// Scoreboard bench for down_timer: expected expire cycles are queued when a
// load is driven and matched against the expire pulses the DUT produces.
module tb_down_timer;
  import timer_pkg::*;

  localparam int W  = 16;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          load_valid;
  logic          load_ready;
  logic [W-1:0]  load_value;
  logic [PW-1:0] load_prescale;
  logic          load_auto;
  logic          stop;
  logic [W-1:0]  count;
  logic          busy;
  logic          expire;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int expQ[$];

  down_timer #(.WIDTH(W), .PS_WIDTH(PW)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .load_valid   (load_valid),
    .load_ready   (load_ready),
    .load_value   (load_value),
    .load_prescale(load_prescale),
    .load_auto    (load_auto),
    .stop         (stop),
    .count        (count),
    .busy         (busy),
    .expire       (expire)
  );

  always #5 clk = ~clk;

  // One clock: count the rising edge, then match expire against the queue at the falling edge.
  task automatic advance();
    int e;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (expire === 1'b1) begin
      total++;
      if (expQ.size() == 0) begin
        bad++;
        $display("[TB] FAIL expire_unexpected: expire=1 at cycle %0d, required no pulse", cyc);
      end else begin
        e = expQ.pop_front();
        if (e != cyc) begin
          bad++;
          $display("[TB] FAIL expire_time: pulse at cycle %0d, required cycle %0d", cyc, e);
        end
      end
    end else if (expire !== 1'b0) begin
      total++;
      bad++;
      $display("[TB] FAIL expire_value: expire=%b at cycle %0d, required 0 or 1", expire, cyc);
    end else if (expQ.size() > 0 && cyc >= expQ[0]) begin
      total++;
      bad++;
      e = expQ.pop_front();
      $display("[TB] FAIL expire_missed: no pulse by cycle %0d, required at cycle %0d", cyc, e);
    end
  endtask

  task automatic driveLoad(input logic [W-1:0] n, input logic [PW-1:0] p, input logic a);
    load_valid    = 1'b1;
    load_value    = n;
    load_prescale = p;
    load_auto     = a;
    advance();
    load_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; stop = 1'b0;
    load_valid = 1'b1; load_value = 16'd9; load_prescale = 8'd0; load_auto = 1'b0;
    advance();
    advance();
    total++;
    if (count !== 16'd0) begin bad++; $display("[TB] FAIL reset_count: got %0d, want 0", count); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b, want 0", busy); end
    total++;
    if (expire !== 1'b0) begin bad++; $display("[TB] FAIL reset_expire: got %b, want 0", expire); end
    rst = 1'b0;
    load_valid = 1'b0;
    advance();
    total++;
    if (load_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_ready: got %b, want 1", load_ready); end
    total++;
    if (busy !== 1'b0 || count !== 16'd0) begin
      bad++; $display("[TB] FAIL reset_noload: busy=%b count=%0d, want busy=0 count=0", busy, count);
    end
  endtask

  task automatic test_one_shot();
    logic [W-1:0] want[3];
    want = '{16'd2, 16'd1, 16'd0};
    en = 1'b1;
    expQ.push_back(cyc + 1 + 3);
    driveLoad(16'd2, 8'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (count !== want[i] || busy !== 1'b1) begin
        bad++; $display("[TB] FAIL oneshot_count[%0d]: count=%0d busy=%b, want count=%0d busy=1", i, count, busy, want[i]);
      end
      advance();
    end
    total++;
    if (busy !== 1'b0 || load_ready !== 1'b1) begin
      bad++; $display("[TB] FAIL oneshot_busy_at_expire: busy=%b ready=%b, want 0/1", busy, load_ready);
    end
    advance();
    total++;
    if (count !== 16'd0 || busy !== 1'b0) begin
      bad++; $display("[TB] FAIL oneshot_hold: count=%0d busy=%b, want 0/0", count, busy);
    end
  endtask

  task automatic test_prescale();
    en = 1'b1;
    expQ.push_back(cyc + 1 + 8);
    driveLoad(16'd1, 8'd3, 1'b0);
    for (int i = 0; i < 9; i++) advance();
    total++;
    if (busy !== 1'b0) begin bad++; $display("[TB] FAIL prescale_idle: busy=%b, want 0", busy); end
    expQ.push_back(cyc + 1 + 16);
    driveLoad(16'd1, 8'd3, 1'b0);
    for (int i = 0; i < 17; i++) begin
      en = (i % 2 == 1);
      advance();
    end
    en = 1'b1;
    total++;
    if (busy !== 1'b0) begin bad++; $display("[TB] FAIL gated_idle: busy=%b, want 0", busy); end
  endtask

  task automatic test_auto_reload();
    int k;
    k = cyc + 1;
    for (int p = 1; p <= 5; p++) expQ.push_back(k + 10 * p);
    driveLoad(16'd4, 8'd1, 1'b1);
    for (int i = 0; i < 50; i++) begin
      advance();
      total++;
      if (busy !== 1'b1) begin bad++; $display("[TB] FAIL auto_busy: busy=%b at cycle %0d, want 1", busy, cyc); end
      if (expire === 1'b1) begin
        total++;
        if (count !== 16'd4) begin bad++; $display("[TB] FAIL auto_reload: count=%0d at cycle %0d, want 4", count, cyc); end
      end
    end
    stop = 1'b1;
    advance();
    stop = 1'b0;
    total++;
    if (busy !== 1'b0) begin bad++; $display("[TB] FAIL auto_stop: busy=%b, want 0", busy); end
    for (int i = 0; i < 12; i++) advance();
  endtask

  task automatic test_stop_collision();
    driveLoad(16'd0, 8'd2, 1'b0);
    advance();
    advance();
    stop = 1'b1;
    advance();
    stop = 1'b0;
    total++;
    if (busy !== 1'b0 || count !== 16'd0 || expire !== 1'b0) begin
      bad++; $display("[TB] FAIL stop_on_step: busy=%b count=%0d expire=%b, want 0/0/0", busy, count, expire);
    end
    for (int i = 0; i < 5; i++) advance();
  endtask

  task automatic test_back_to_back();
    int k;
    k = cyc + 1;
    expQ.push_back(k + 6);
    driveLoad(16'd5, 8'd0, 1'b0);
    total++;
    if (count !== 16'd5) begin bad++; $display("[TB] FAIL run_load_start: count=%0d, want 5", count); end
    load_valid = 1'b1; load_value = 16'd7;
    advance();
    total++;
    if (count !== 16'd4) begin bad++; $display("[TB] FAIL run_load_ignored1: count=%0d, want 4", count); end
    advance();
    load_valid = 1'b0;
    total++;
    if (count !== 16'd3) begin bad++; $display("[TB] FAIL run_load_ignored2: count=%0d, want 3", count); end
    while (cyc < k + 6) advance();
    total++;
    if (load_ready !== 1'b1) begin bad++; $display("[TB] FAIL expire_ready: ready=%b, want 1", load_ready); end
    expQ.push_back(cyc + 1 + 2);
    driveLoad(16'd1, 8'd0, 1'b0);
    total++;
    if (count !== 16'd1 || busy !== 1'b1) begin
      bad++; $display("[TB] FAIL b2b_start: count=%0d busy=%b, want 1/1", count, busy);
    end
    advance();
    advance();
    total++;
    if (busy !== 1'b0) begin bad++; $display("[TB] FAIL b2b_done: busy=%b, want 0", busy); end
  endtask

  task automatic test_reset_mid_run();
    int guard;
    guard = 0;
    driveLoad(16'd100, 8'd0, 1'b0);
    while (count !== 16'd50 && guard < 200) begin
      advance();
      guard++;
    end
    total++;
    if (count !== 16'd50) begin bad++; $display("[TB] FAIL midrun_reach50: count=%0d after %0d cycles, want 50", count, guard); end
    rst = 1'b1;
    advance();
    rst = 1'b0;
    total++;
    if (count !== 16'd0 || busy !== 1'b0 || expire !== 1'b0) begin
      bad++; $display("[TB] FAIL midrun_reset: count=%0d busy=%b expire=%b, want 0/0/0", count, busy, expire);
    end
    for (int i = 0; i < 110; i++) advance();
  endtask

  initial begin
    test_reset();
    test_one_shot();
    test_prescale();
    test_auto_reload();
    test_stop_collision();
    test_back_to_back();
    test_reset_mid_run();
    total++;
    if (expQ.size() != 0) begin
      bad++; $display("[TB] FAIL scoreboard_drain: %0d pulses outstanding, want 0", expQ.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
